esa32_error_monitor: RTL and testbench
======================================

ESA32_ERROR_MONITOR -- requirements
Module: esa32_error_monitor

Interface
REQ-001 Parameter WINDOW, default 256, number of samples per measurement window (2..65535).
REQ-002 Parameter ACC_W, default 48, width of the error-distance accumulator (>=33).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  pulse that clears statistics and opens a window.
REQ-006 valid_i  input  1  sample present on add1_i/add2_i/approx_i.
REQ-007 ready_o  output  1  monitor accepts a sample this cycle.
REQ-008 add1_i  input  32  first adder operand.
REQ-009 add2_i  input  32  second adder operand.
REQ-010 approx_i  input  33  approximate sum from equal_segmentation_adder32.
REQ-011 busy_o  output  1  window open or pipeline draining.
REQ-012 done_o  output  1  one-cycle pulse when the window report is valid.
REQ-013 err_count_o  output  16  samples with nonzero error distance.
REQ-014 max_ed_o  output  33  largest error distance in the window.
REQ-015 sum_ed_o  output  ACC_W  sum of error distances in the window.

Function
REQ-016 Error distance SHALL be ED = |({1'b0,add1_i}+{1'b0,add2_i}) - approx_i|, computed at 33 bits.
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN, REPORT.
REQ-018 IDLE: ready_o=0, busy_o=0; start_i SHALL clear all stats and the sample counter and enter RUN next cycle.
REQ-019 RUN: ready_o=1, busy_o=1; a sample is accepted when valid_i && ready_o.
REQ-020 On the WINDOW-th accepted sample the FSM SHALL enter DRAIN, and ready_o SHALL be 0 from the following cycle.
REQ-021 Pipeline SHALL be 2 stages: stage 1 registers the exact sum and approx_i; stage 2 registers ED and updates the stats.
REQ-022 A sample accepted in cycle N SHALL be reflected in the stats outputs in cycle N+2.
REQ-023 DRAIN SHALL last exactly 2 cycles with busy_o=1, then enter REPORT.
REQ-024 REPORT SHALL assert done_o for one cycle and go to IDLE; stats outputs SHALL hold until the next start_i.
REQ-025 start_i in RUN, DRAIN or REPORT SHALL be ignored.
REQ-026 valid_i while ready_o=0 SHALL be dropped, with no effect on state.
REQ-027 sum_ed_o SHALL saturate at all-ones; err_count_o SHALL saturate at 16'hFFFF.
REQ-028 max_ed_o SHALL update only when the new ED is strictly greater than the stored maximum.
REQ-029 Stats outputs SHALL be driven directly from registers.

Reset
REQ-030 rst_i SHALL force IDLE and set ready_o, busy_o, done_o, err_count_o, max_ed_o, sum_ed_o, the sample counter and all pipeline valids to 0.
REQ-031 rst_i mid-window SHALL discard in-flight samples; no done_o SHALL follow.
REQ-032 rst_i SHALL take priority over start_i in the same cycle.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, ED_W=33 and the err_count width constant.
REQ-034 ED computation SHALL be one sub-module, esa32_ed_calc (registered exact sum, combinational abs-difference).
REQ-035 Window counting and stats SHALL stay in the top module.

Verification (bench uses WINDOW=4)
REQ-036 Exact samples: 4 samples with approx_i equal to the true sum (e.g. 0x29AF2430+0x7A1B9ABC with approx 0x0A3CABEEC) -> err_count_o=0, max_ed_o=0, sum_ed_o=0, done_o pulses once.
REQ-037 Mixed error: EDs 0x100, 0, 0x10000, 0x1 -> err_count_o=3, max_ed_o=0x10000, sum_ed_o=0x10101.
REQ-038 Backpressure and gaps: valid_i toggles 1,0,1,1,0,1 -> exactly 4 samples accepted; valid_i held after the 4th accept is ignored; done_o fires 2 cycles after the DRAIN entry cycle.
REQ-039 Reset mid-window: rst_i after 2 samples -> all outputs 0, state IDLE, no done_o.
REQ-040 Start ignored: start_i in RUN -> counts unchanged; a new start_i after done_o clears the stats.
REQ-041 Saturation (ACC_W=33): 4 samples with ED=0x1FFFFFFFF -> sum_ed_o stays at 0x1FFFFFFFF.

Source files
------------

// File: rtl/esa32_error_monitor_pkg.sv
// esa32_error_monitor_pkg: shared FSM state type and widths for the error monitor
package esa32_error_monitor_pkg;
  localparam int ED_W = 33;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;
endpackage

// File: rtl/esa32_ed_calc.sv
// esa32_ed_calc: registers the exact sum and approximate sum, then forms |exact - approx|
module esa32_ed_calc
  import esa32_error_monitor_pkg::*;
(
  input  logic            clk,
  input  logic            en,
  input  logic [31:0]     add1,
  input  logic [31:0]     add2,
  input  logic [ED_W-1:0] approx,
  output logic [ED_W-1:0] ed
);
  logic [ED_W-1:0] exact, apx;
  always_ff @(posedge clk)
    if (en) begin
      exact <= {1'b0, add1} + {1'b0, add2};
      apx <= approx;
    end
  assign ed = exact >= apx ? exact - apx : apx - exact;
endmodule

// File: rtl/esa32_error_monitor.sv
// esa32_error_monitor: windowed error-distance statistics for an approximate 32-bit adder
module esa32_error_monitor
  import esa32_error_monitor_pkg::*;
#(
  parameter int WINDOW = 256,
  parameter int ACC_W = 48
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      add1_i,
  input  logic [31:0]      add2_i,
  input  logic [ED_W-1:0]  approx_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [ED_W-1:0]  max_ed_o,
  output logic [ACC_W-1:0] sum_ed_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic s1_valid, drain, accept, clear;
  logic [ED_W-1:0] ed;
  logic [ACC_W:0] sum_ext;
  assign accept = valid_i && ready_o;
  assign clear = state == IDLE && start_i;
  assign sum_ext = {1'b0, sum_ed_o} + {{(ACC_W + 1 - ED_W){1'b0}}, ed};
  esa32_ed_calc u_ed (
    .clk(clk_i),
    .en(accept),
    .add1(add1_i),
    .add2(add2_i),
    .approx(approx_i),
    .ed(ed)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ready_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      cnt <= '0;
      s1_valid <= 1'b0;
      drain <= 1'b0;
    end else begin
      s1_valid <= accept;
      done_o <= 1'b0;
      case (state)
        IDLE:
          if (start_i) begin
            state <= RUN;
            ready_o <= 1'b1;
            busy_o <= 1'b1;
            cnt <= '0;
          end
        RUN:
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= DRAIN;
              ready_o <= 1'b0;
              drain <= 1'b0;
            end
          end
        DRAIN: begin
          drain <= 1'b1;
          if (drain) begin
            state <= REPORT;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  // Stage 2: stats absorb the combinational ED of the sample registered one cycle earlier
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      err_count_o <= '0;
      max_ed_o <= '0;
      sum_ed_o <= '0;
    end else if (s1_valid) begin
      if (|ed && !(&err_count_o)) err_count_o <= err_count_o + 1'b1;
      if (ed > max_ed_o) max_ed_o <= ed;
      sum_ed_o <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    end
  end
endmodule

// File: tb/tb_esa32_error_monitor.sv
// tb_esa32_error_monitor: directed windows with a report scoreboard checked on done_o
module tb_esa32_error_monitor;
  logic clk = 1'b0;
  logic rst_i, start_i, valid_i, ready_o, busy_o, done_o;
  logic [31:0] add1_i, add2_i;
  logic [32:0] approx_i, max_ed_o, sum_ed_o;
  logic [15:0] err_count_o;
  int checks = 0, errors = 0, cyc = 0, acc_cnt = 0, last_acc = 0;
  typedef struct {
    logic [63:0] err;
    logic [63:0] mx;
    logic [63:0] sum;
    int at;
  } rep_t;
  rep_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  esa32_error_monitor #(.WINDOW(4), .ACC_W(33)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .valid_i(valid_i), .ready_o(ready_o),
    .add1_i(add1_i), .add2_i(add2_i), .approx_i(approx_i), .busy_o(busy_o), .done_o(done_o),
    .err_count_o(err_count_o), .max_ed_o(max_ed_o), .sum_ed_o(sum_ed_o)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk)
    if (done_o === 1'b1) begin
      if (q.size() == 0) chk("spurious_done", 64'(done_o), 64'd0);
      else begin
        rep_t r;
        r = q.pop_front();
        chk("err_count", 64'(err_count_o), r.err);
        chk("max_ed", 64'(max_ed_o), r.mx);
        chk("sum_ed", 64'(sum_ed_o), r.sum);
        chk("done_cycle", 64'(cyc), 64'(r.at));
      end
    end

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [32:0] x);
    logic r;
    int n;
    valid_i = v; add1_i = a; add2_i = b; approx_i = x;
    n = cyc; r = ready_o;
    @(posedge clk); #1;
    if (v && r) begin acc_cnt++; last_acc = n; end
    valid_i = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [32:0] x);
    int k;
    k = acc_cnt;
    for (int t = 0; t < 20 && acc_cnt == k; t++) drive(1'b1, a, b, x);
    if (acc_cnt == k) chk("accept_timeout", 64'(acc_cnt), 64'(k + 1));
  endtask

  task automatic expect_rep(input logic [63:0] e, input logic [63:0] m, input logic [63:0] s);
    q.push_back('{e, m, s, last_acc + 3});
  endtask

  task automatic start_win();
    acc_cnt = 0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 40 && q.size() > 0; t++) begin
      @(posedge clk); #1;
    end
    if (q.size() != 0) chk("done_timeout", 64'(q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; valid_i = 1'b0;
    add1_i = '0; add2_i = '0; approx_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("rst_ready", 64'(ready_o), 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_done", 64'(done_o), 0);
    chk("rst_err", 64'(err_count_o), 0);
    chk("rst_max", 64'(max_ed_o), 0);
    chk("rst_sum", 64'(sum_ed_o), 0);
    // exact samples
    start_win();
    chk("run_ready", 64'(ready_o), 1);
    chk("run_busy", 64'(busy_o), 1);
    push(32'h29AF2430, 32'h7A1B9ABC, 33'h0A3CABEEC);
    push(32'hFFFFFFFF, 32'hFFFFFFFF, 33'h1FFFFFFFE);
    push(32'h0, 32'h0, 33'h0);
    push(32'h12345678, 32'h1, 33'h012345679);
    expect_rep(0, 0, 0);
    wait_idle();
    // mixed error: 0x100, 0, 0x10000, 1
    start_win();
    push(32'h1000, 32'h0, 33'h1100);
    push(32'h5, 32'h5, 33'hA);
    push(32'h20000, 32'h0, 33'h10000);
    push(32'hFFFFFFFF, 32'h1, 33'h0FFFFFFFF);
    expect_rep(3, 33'h10000, 33'h10101);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_sum", 64'(sum_ed_o), 64'h10101);
    chk("hold_err", 64'(err_count_o), 3);
    // backpressure and gaps: EDs 2,3,1,5; gaps carry a large ED
    start_win();
    drive(1'b1, 32'd10, 32'd0, 33'd12);
    drive(1'b0, 32'd0, 32'd0, 33'h100000000);
    drive(1'b1, 32'd10, 32'd0, 33'd7);
    drive(1'b1, 32'd0, 32'd0, 33'd1);
    drive(1'b0, 32'd0, 32'd0, 33'h100000000);
    drive(1'b1, 32'd5, 32'd5, 33'd5);
    chk("bp_accepts", 64'(acc_cnt), 4);
    expect_rep(4, 5, 33'hB);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready_low", 64'(ready_o), 0);
      drive(1'b1, 32'd0, 32'd0, 33'd7);
    end
    chk("bp_accepts_after", 64'(acc_cnt), 4);
    wait_idle();
    // reset mid-window, with start asserted alongside reset
    start_win();
    push(32'd0, 32'd0, 33'd8);
    push(32'd0, 32'd0, 33'd8);
    rst_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0; start_i = 1'b0;
    chk("mid_rst_ready", 64'(ready_o), 0);
    chk("mid_rst_busy", 64'(busy_o), 0);
    chk("mid_rst_err", 64'(err_count_o), 0);
    chk("mid_rst_max", 64'(max_ed_o), 0);
    chk("mid_rst_sum", 64'(sum_ed_o), 0);
    repeat (8) @(posedge clk);
    #1;
    chk("mid_rst_idle_busy", 64'(busy_o), 0);
    // start ignored in RUN, new start clears stats
    start_win();
    push(32'd0, 32'd0, 33'd4);
    start_i = 1'b1;
    push(32'd0, 32'd0, 33'd4);
    start_i = 1'b0;
    push(32'd0, 32'd0, 33'd4);
    push(32'd0, 32'd0, 33'd4);
    expect_rep(4, 4, 33'h10);
    wait_idle();
    start_win();
    chk("restart_err", 64'(err_count_o), 0);
    chk("restart_max", 64'(max_ed_o), 0);
    chk("restart_sum", 64'(sum_ed_o), 0);
    for (int i = 0; i < 4; i++) push(32'd7, 32'd9, 33'd16);
    expect_rep(0, 0, 0);
    wait_idle();
    // saturation of the 33-bit accumulator
    start_win();
    for (int i = 0; i < 4; i++) push(32'd0, 32'd0, 33'h1FFFFFFFF);
    expect_rep(4, 33'h1FFFFFFFF, 33'h1FFFFFFFF);
    wait_idle();
    chk("queue_empty", 64'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
